riscv_mc_ctrl: RTL and testbench
================================

// Module: riscv_mc_ctrl
// PURPOSE
//  Multi-cycle control FSM sequencing the RV32I core datapath (PC, IR, regfile, ALU, memory port).
//  Decodes the latched instruction and drives per-state enables/selects for FETCH, DECODE, EXEC, MEM and WB.
//  Owns halt: stops on ECALL, illegal opcode or memory timeout. Sits inside riscv_core beside the regfile.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may stay high without mem_ready before error halt (>=1)
// PORTS
//  clk           in   1   core clock; all state on rising edge
//  rst_b         in   1   reset, asynchronous, active-low
//  inst          in   32  IR contents; valid from DECODE until next FETCH completes
//  mem_ready     in   1   memory completes current access this cycle
//  alu_zero      in   1   ALU result == 0 (EXEC of branches)
//  ir_we         out  1   latch memory read data into IR
//  pc_we         out  1   update PC this cycle
//  pc_src        out  2   0=PC+4, 1=PC+imm (branch/JAL), 2=(ALU result)&~1 (JALR)
//  rf_we         out  1   regfile write enable (never asserted when rd==x0)
//  wb_sel        out  2   0=ALU result, 1=load data, 2=PC+4
//  alu_op        out  4   0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B
//  alu_src_a     out  1   0=rs1, 1=PC
//  alu_src_b     out  1   0=rs2, 1=immediate
//  mem_req       out  1   memory access request
//  mem_addr_sel  out  1   0=PC (fetch), 1=ALU result (load/store)
//  mem_write_en  out  1   store; only with mem_req in MEM
//  retire        out  1   one-cycle pulse on last cycle of each completed instruction
//  halted        out  1   sticky; set on entry to HALT
//  err           out  2   0 none/ECALL, 1 illegal opcode, 2 memory timeout; sticky
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, every output 0; applies immediately mid-instruction, in-flight access abandoned.
//  Outputs combinational from state + inst; enables asserted for exactly one cycle per use.
//  FETCH: mem_req=1, mem_addr_sel=0; on mem_ready: ir_we=1 -> DECODE.
//  DECODE: opcode check; 0x73 -> HALT err=0; unknown opcode (not 33,13,03,23,63,6F,67,37,17) -> HALT err=1; else -> EXEC.
//  EXEC: R(0x33): alu_op from funct3 + funct7[5] (SUB/SRA when set) -> WB. I(0x13): same, funct7[5] honoured only for funct3=5.
//    LOAD/STORE: ADD rs1+imm -> MEM. LUI: PASS_B imm -> WB. AUIPC: ADD, src_a=PC -> WB.
//    BRANCH: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU; taken = (funct3 in {0,5,7}) ? alu_zero : !alu_zero,
//    where zero on SLT/SLTU means "not less"; pc_we=1, pc_src=taken?1:0, retire=1 -> FETCH. funct3 2/3 -> HALT err=1.
//    JAL/JALR: -> WB (JALR computes rs1+imm in EXEC).
//  MEM: mem_req=1, mem_addr_sel=1, mem_write_en=(STORE); on mem_ready: LOAD -> WB; STORE: pc_we=1, pc_src=0, retire=1 -> FETCH.
//  WB: rf_we=(rd!=0), wb_sel per class (LOAD 1, JAL/JALR 2, else 0), pc_we=1, pc_src (JAL 1, JALR 2, else 0), retire=1 -> FETCH.
//  Latency (zero-wait memory): branch 3, store 4, ALU/LUI/AUIPC/JAL/JALR 4, load 5 cycles.
//  Timeout: counter clears on entry to FETCH/MEM, increments each cycle mem_req=1 && !mem_ready;
//    reaching MEM_TIMEOUT without ready -> HALT err=2. mem_ready in the MEM_TIMEOUT-th cycle wins (no error).
//  HALT: all enables 0, halted=1; exits only by reset.
// CONFIGURATION
//  RISCV_CTRL_PERF_EN defined: adds outputs cycle_cnt[31:0] (increments every non-HALT cycle) and
//    instret_cnt[31:0] (increments on retire); both reset to 0, wrap modulo 2^32, freeze in HALT.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  add x3,x1,x2 (0x002081B3), mem_ready=1 -> alu_op=0, rf_we=1 in cycle 4, retire same cycle, pc_src=0.
//  sub/sra (funct7=0x20) -> alu_op 1/7; addi with imm[10]=1 funct3=0 -> alu_op 0 (not SUB).
//  lw with mem_ready low 3 cycles in MEM -> WB on cycle 8, wb_sel=1; sw -> mem_write_en=1 only in MEM.
//  beq with alu_zero=1 -> pc_we=1, pc_src=1 in cycle 3; bne alu_zero=1 -> pc_src=0.
//  mem_ready never high in FETCH, MEM_TIMEOUT=16 -> halted=1, err=2 after 16 cycles; illegal 0x0000007F -> err=1.
//  rst_b low mid-MEM -> outputs 0 same cycle, FETCH after release; perf counters (PERF_EN) back to 0.

Source files
------------

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and owns halt/error state.
// Optional RISCV_CTRL_PERF_EN adds cycle_cnt / instret_cnt performance counters.
module riscv_mc_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        alu_zero,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [3:0]  alu_op,
    output logic        alu_src_a,
    output logic        alu_src_b,
    output logic        mem_req,
    output logic        mem_addr_sel,
    output logic        mem_write_en,
    output logic        retire,
    output logic        halted,
    output logic [1:0]  err
`ifdef RISCV_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    localparam logic [6:0] OP_OP     = 7'h33;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_SYSTEM = 7'h73;

    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_SLL    = 4'd2;
    localparam logic [3:0] ALU_SLT    = 4'd3;
    localparam logic [3:0] ALU_SLTU   = 4'd4;
    localparam logic [3:0] ALU_XOR    = 4'd5;
    localparam logic [3:0] ALU_SRL    = 4'd6;
    localparam logic [3:0] ALU_SRA    = 4'd7;
    localparam logic [3:0] ALU_OR     = 4'd8;
    localparam logic [3:0] ALU_AND    = 4'd9;
    localparam logic [3:0] ALU_PASS_B = 4'd10;

    localparam logic [1:0] PC_SEQ  = 2'd0;
    localparam logic [1:0] PC_REL  = 2'd1;
    localparam logic [1:0] PC_JALR = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]         err_q, err_d;

    logic        ir_we_c, pc_we_c, rf_we_c, alu_src_a_c, alu_src_b_c;
    logic        mem_req_c, mem_addr_sel_c, mem_write_en_c, retire_c, halted_c;
    logic [1:0]  pc_src_c, wb_sel_c;
    logic [3:0]  alu_op_c;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        legal_op;
    logic        br_taken;
    logic        unused_inst;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign rd          = inst[11:7];
    assign unused_inst = ^{inst[31], inst[29:15]};
    assign legal_op    = opcode inside {OP_OP, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
                                        OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
    // ALU zero after SLT/SLTU means "not less", so BGE/BGEU share polarity with BEQ
    assign br_taken    = (funct3 == 3'd0 || funct3 == 3'd5 || funct3 == 3'd7) ? alu_zero : !alu_zero;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        err_d          = err_q;
        ir_we_c        = 1'b0;
        pc_we_c        = 1'b0;
        pc_src_c       = PC_SEQ;
        rf_we_c        = 1'b0;
        wb_sel_c       = WB_ALU;
        alu_op_c       = ALU_ADD;
        alu_src_a_c    = 1'b0;
        alu_src_b_c    = 1'b0;
        mem_req_c      = 1'b0;
        mem_addr_sel_c = 1'b0;
        mem_write_en_c = 1'b0;
        retire_c       = 1'b0;
        halted_c       = 1'b0;

        // ALU controls held EXEC..WB so the ALU result stays valid for the MEM address and JALR target
        if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
            case (opcode)
                OP_OP:     alu_op_c = alu_from_f3(funct3, inst[30]);
                OP_IMM: begin
                    alu_op_c    = alu_from_f3(funct3, inst[30] && (funct3 == 3'd5));
                    alu_src_b_c = 1'b1;
                end
                OP_LOAD, OP_STORE, OP_JALR: alu_src_b_c = 1'b1;
                OP_LUI: begin
                    alu_op_c    = ALU_PASS_B;
                    alu_src_b_c = 1'b1;
                end
                OP_AUIPC: begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 1'b1;
                end
                OP_BRANCH: begin
                    case (funct3[2:1])
                        2'b00:   alu_op_c = ALU_SUB;
                        2'b10:   alu_op_c = ALU_SLT;
                        2'b11:   alu_op_c = ALU_SLTU;
                        default: alu_op_c = ALU_ADD;
                    endcase
                end
                default: ;
            endcase
        end

        case (state_q)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_d = S_HALT;
                    err_d   = ERR_NONE;
                end else if (!legal_op) begin
                    state_d = S_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LOAD, OP_STORE: begin
                        state_d    = S_MEM;
                        wait_cnt_d = '0;
                    end
                    OP_BRANCH: begin
                        if (funct3[2:1] == 2'b01) begin
                            state_d = S_HALT;
                            err_d   = ERR_ILLEGAL;
                        end else begin
                            pc_we_c    = 1'b1;
                            pc_src_c   = br_taken ? PC_REL : PC_SEQ;
                            retire_c   = 1'b1;
                            state_d    = S_FETCH;
                            wait_cnt_d = '0;
                        end
                    end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_write_en_c = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_we_c    = 1'b1;
                        retire_c   = 1'b1;
                        state_d    = S_FETCH;
                        wait_cnt_d = '0;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we_c = (rd != 5'd0);
                case (opcode)
                    OP_LOAD: wb_sel_c = WB_LOAD;
                    OP_JAL: begin
                        wb_sel_c = WB_PC4;
                        pc_src_c = PC_REL;
                    end
                    OP_JALR: begin
                        wb_sel_c = WB_PC4;
                        pc_src_c = PC_JALR;
                    end
                    default: ;
                endcase
                pc_we_c    = 1'b1;
                retire_c   = 1'b1;
                state_d    = S_FETCH;
                wait_cnt_d = '0;
            end
            S_HALT:  halted_c = 1'b1;
            default: state_d = S_HALT;
        endcase

        // Ready in the final allowed cycle wins; otherwise the stalled access halts the core
        if (mem_req_c && !mem_ready) begin
            if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                state_d = S_HALT;
                err_d   = ERR_TIMEOUT;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
            err_q      <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Reset forces every output low in the same cycle, even though the state already reads FETCH
    assign {ir_we, pc_we, pc_src, rf_we, wb_sel, alu_op, alu_src_a, alu_src_b,
            mem_req, mem_addr_sel, mem_write_en, retire, halted} =
           rst_b ? {ir_we_c, pc_we_c, pc_src_c, rf_we_c, wb_sel_c, alu_op_c, alu_src_a_c,
                    alu_src_b_c, mem_req_c, mem_addr_sel_c, mem_write_en_c, retire_c, halted_c}
                 : '0;
    assign err = err_q;

`ifdef RISCV_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d, instret_cnt_q, instret_cnt_d;

    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != S_HALT) begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            if (retire_c) begin
                instret_cnt_d = instret_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: per-instruction cycle-plan model checked every cycle, plus literal spot checks.
module tb_riscv_mc_ctrl;

    localparam int unsigned MT = 16;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic [31:0] inst = '0;
    logic        mem_ready = 1'b0;
    logic        alu_zero = 1'b0;
    logic        ir_we, pc_we, rf_we, alu_src_a, alu_src_b, mem_req, mem_addr_sel;
    logic        mem_write_en, retire, halted;
    logic [1:0]  pc_src, wb_sel, err;
    logic [3:0]  alu_op;
`ifdef RISCV_CTRL_PERF_EN
    logic [31:0] cycle_cnt, instret_cnt;
    logic [31:0] exp_cc = '0, exp_ir = '0;
`endif

    riscv_mc_ctrl #(.MEM_TIMEOUT(MT)) dut (
        .clk(clk), .rst_b(rst_b), .inst(inst), .mem_ready(mem_ready), .alu_zero(alu_zero),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we), .wb_sel(wb_sel),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .mem_req(mem_req),
        .mem_addr_sel(mem_addr_sel), .mem_write_en(mem_write_en), .retire(retire),
        .halted(halted), .err(err)
`ifdef RISCV_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       rf_we;
        logic [1:0] wb_sel;
        logic [3:0] alu_op;
        logic       src_a;
        logic       src_b;
        logic       mem_req;
        logic       addr_sel;
        logic       mem_we;
        logic       retire;
        logic       halted;
        logic [1:0] err;
    } ov_t;

    ov_t act;
    assign act = {ir_we, pc_we, pc_src, rf_we, wb_sel, alu_op, alu_src_a, alu_src_b,
                  mem_req, mem_addr_sel, mem_write_en, retire, halted, err};

    // alu_op by {funct7[5], funct3}; branch alu_op by funct3
    int r_tab  [16] = '{0, 2, 3, 4, 5, 6, 8, 9, 1, 2, 3, 4, 5, 7, 8, 9};
    int br_tab [8]  = '{1, 1, 0, 0, 3, 3, 4, 4};

    ov_t        expq[$];
    ov_t        cmp_e;
    ov_t        ret_vec = '0;
    int         n_tests = 0, n_fail = 0;
    int         cyc = 0, start_cyc = 0, ret_lat = 0, halt_lat = 0, we_cnt = 0;
    logic       prev_halt = 1'b0;
    logic [1:0] cur_err = 2'd0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic ov_t idle();
        ov_t e;
        e     = '0;
        e.err = cur_err;
        return e;
    endfunction

    function automatic ov_t alu_vec(input logic [31:0] i);
        ov_t        e;
        logic [2:0] f3;
        e  = idle();
        f3 = i[14:12];
        case (i[6:0])
            7'h33: e.alu_op = 4'(r_tab[{i[30], f3}]);
            7'h13: begin
                e.alu_op = 4'(r_tab[{i[30] && (f3 == 3'd5), f3}]);
                e.src_b  = 1'b1;
            end
            7'h03, 7'h23, 7'h67: e.src_b = 1'b1;
            7'h37: begin
                e.alu_op = 4'd10;
                e.src_b  = 1'b1;
            end
            7'h17: begin
                e.src_a = 1'b1;
                e.src_b = 1'b1;
            end
            7'h63: e.alu_op = 4'(br_tab[f3]);
            default: ;
        endcase
        return e;
    endfunction

    task automatic step(input logic rdy, input logic z, input ov_t e);
        mem_ready = rdy;
        alu_zero  = z;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic halt_cycles(input logic [1:0] code);
        ov_t e;
        cur_err  = code;
        e        = idle();
        e.halted = 1'b1;
        repeat (3) step(1'b1, 1'b1, e);
    endtask

    task automatic do_reset();
        cur_err = 2'd0;
        rst_b   = 1'b0;
        step(1'b0, 1'b0, '0);
        rst_b = 1'b1;
    endtask

    // One instruction: fwait/mwait = not-ready cycles before ready in FETCH/MEM
    task automatic run_instr(input logic [31:0] i, input int fwait, input int mwait, input logic z);
        ov_t        e;
        logic [6:0] op;
        logic [2:0] f3;
        op        = i[6:0];
        f3        = i[14:12];
        inst      = i;
        start_cyc = cyc;
        we_cnt    = 0;
        for (int k = 0; k <= fwait && k < int'(MT); k++) begin
            e         = idle();
            e.mem_req = 1'b1;
            e.ir_we   = (k == fwait);
            step(k == fwait, 1'b0, e);
        end
        if (fwait >= int'(MT)) begin
            halt_cycles(2'd2);
            return;
        end
        step(1'b0, 1'b0, idle());
        if (op == 7'h73) begin
            halt_cycles(2'd0);
            return;
        end
        if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17})) begin
            halt_cycles(2'd1);
            return;
        end
        e = alu_vec(i);
        if (op == 7'h63) begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
                step(1'b0, z, e);
                halt_cycles(2'd1);
                return;
            end
            e.pc_we  = 1'b1;
            e.pc_src = ((f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd7) ? z : !z) ? 2'd1 : 2'd0;
            e.retire = 1'b1;
            step(1'b0, z, e);
            return;
        end
        step(1'b0, z, e);
        if (op == 7'h03 || op == 7'h23) begin
            for (int k = 0; k <= mwait && k < int'(MT); k++) begin
                e          = alu_vec(i);
                e.mem_req  = 1'b1;
                e.addr_sel = 1'b1;
                e.mem_we   = (op == 7'h23);
                if (k == mwait && op == 7'h23) begin
                    e.pc_we  = 1'b1;
                    e.retire = 1'b1;
                end
                step(k == mwait, 1'b0, e);
            end
            if (mwait >= int'(MT)) begin
                halt_cycles(2'd2);
                return;
            end
            if (op == 7'h23) return;
        end
        e        = alu_vec(i);
        e.rf_we  = (i[11:7] != 5'd0);
        e.wb_sel = (op == 7'h03) ? 2'd1 : (op == 7'h6F || op == 7'h67) ? 2'd2 : 2'd0;
        e.pc_src = (op == 7'h6F) ? 2'd1 : (op == 7'h67) ? 2'd2 : 2'd0;
        e.pc_we  = 1'b1;
        e.retire = 1'b1;
        step(1'b0, 1'b0, e);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (expq.size() > 0) begin
            cmp_e = expq.pop_front();
            chk($sformatf("outputs cyc %0d", cyc), 32'(act), 32'(cmp_e));
`ifdef RISCV_CTRL_PERF_EN
            if (!rst_b) begin
                exp_cc = '0;
                exp_ir = '0;
            end
            chk("cycle_cnt", cycle_cnt, exp_cc);
            chk("instret_cnt", instret_cnt, exp_ir);
            if (rst_b && !cmp_e.halted) exp_cc = exp_cc + 32'd1;
            if (rst_b && cmp_e.retire) exp_ir = exp_ir + 32'd1;
`endif
        end
        if (act.retire) begin
            ret_lat = cyc - start_cyc;
            ret_vec = act;
        end
        if (act.mem_we) we_cnt++;
        if (act.halted && !prev_halt) halt_lat = cyc - start_cyc;
        prev_halt = act.halted;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ov_t e;
        #3;
        chk("reset outputs", 32'(act), 32'd0);
        chk("reset mem_req", 32'(mem_req), 32'd0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        run_instr(32'h002081B3, 0, 0, 1'b0);
        chk("add latency", ret_lat, 4);
        chk("add alu_op", 32'(ret_vec.alu_op), 0);
        chk("add rf_we", 32'(ret_vec.rf_we), 1);
        chk("add pc_src", 32'(ret_vec.pc_src), 0);

        run_instr(32'h402081B3, 0, 0, 1'b0);
        chk("sub alu_op", 32'(ret_vec.alu_op), 1);
        run_instr(32'h4020D1B3, 0, 0, 1'b0);
        chk("sra alu_op", 32'(ret_vec.alu_op), 7);
        run_instr(32'h40000093, 0, 0, 1'b0);
        chk("addi imm10 alu_op", 32'(ret_vec.alu_op), 0);
        run_instr(32'h4030D093, 0, 0, 1'b0);
        chk("srai alu_op", 32'(ret_vec.alu_op), 7);

        run_instr(32'h0000A283, 0, 3, 1'b0);
        chk("lw latency", ret_lat, 8);
        chk("lw wb_sel", 32'(ret_vec.wb_sel), 1);
        run_instr(32'h0050A223, 0, 0, 1'b0);
        chk("sw latency", ret_lat, 4);
        chk("sw write cycles", we_cnt, 1);

        run_instr(32'h00208463, 0, 0, 1'b1);
        chk("beq latency", ret_lat, 3);
        chk("beq pc_src", 32'(ret_vec.pc_src), 1);
        run_instr(32'h00209463, 0, 0, 1'b1);
        chk("bne pc_src", 32'(ret_vec.pc_src), 0);
        run_instr(32'h0020C463, 0, 0, 1'b0);
        chk("blt pc_src", 32'(ret_vec.pc_src), 1);
        run_instr(32'h0020F463, 0, 0, 1'b0);
        chk("bgeu pc_src", 32'(ret_vec.pc_src), 0);

        run_instr(32'h123453B7, 0, 0, 1'b0);
        run_instr(32'h00001397, 1, 0, 1'b0);
        run_instr(32'h008000EF, 0, 0, 1'b0);
        chk("jal wb_sel", 32'(ret_vec.wb_sel), 2);
        chk("jal pc_src", 32'(ret_vec.pc_src), 1);
        run_instr(32'h00008067, 0, 0, 1'b0);
        chk("jalr rf_we x0", 32'(ret_vec.rf_we), 0);
        chk("jalr pc_src", 32'(ret_vec.pc_src), 2);
        run_instr(32'h00208033, 0, 0, 1'b0);
        chk("add x0 rf_we", 32'(ret_vec.rf_we), 0);
        run_instr(32'h002081B3, 15, 0, 1'b0);
        chk("ready at limit latency", ret_lat, 19);
        chk("ready at limit halted", 32'(halted), 0);

        inst = 32'h0000A283;
        e = idle();
        e.mem_req = 1'b1;
        e.ir_we = 1'b1;
        step(1'b1, 1'b0, e);
        step(1'b0, 1'b0, idle());
        step(1'b0, 1'b0, alu_vec(inst));
        e = alu_vec(inst);
        e.mem_req = 1'b1;
        e.addr_sel = 1'b1;
        step(1'b0, 1'b0, e);
        do_reset();
        run_instr(32'h002081B3, 0, 0, 1'b0);
        chk("after reset latency", ret_lat, 4);

        run_instr(32'h00000073, 0, 0, 1'b0);
        chk("ecall halted", 32'(halted), 1);
        chk("ecall err", 32'(err), 0);
        do_reset();
        run_instr(32'h0000007F, 0, 0, 1'b0);
        chk("illegal err", 32'(err), 1);
        do_reset();
        run_instr(32'h002081B3, 100, 0, 1'b0);
        chk("timeout halt cycle", halt_lat, 17);
        chk("timeout err", 32'(err), 2);
        do_reset();
        run_instr(32'h0000A283, 0, 100, 1'b0);
        chk("mem timeout err", 32'(err), 2);
        do_reset();
        run_instr(32'h0020A463, 0, 0, 1'b0);
        chk("bad branch err", 32'(err), 1);
        do_reset();
        run_instr(32'h0050A223, 0, 2, 1'b0);
        chk("sw wait latency", ret_lat, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
